aq_reduce_ctrl: RTL and testbench

AQ_REDUCE_CTRL -- requirements
Module: aq_reduce_ctrl

---
 rtl/aq_reduce_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_aq_reduce_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_reduce_ctrl.sv
// aq_reduce_ctrl: DDA-based AXI-Stream frame decimator, ORG_X x ORG_Y in, CNV_X x CNV_Y out.
// Define AQ_REDUCE_TLAST_CHECK_EN to build the sticky S_TLAST line-length checker behind LINE_ERR.
module aq_reduce_ctrl #(
    parameter int DATA_W = 24
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [15:0]       ORG_X,
    input  logic [15:0]       ORG_Y,
    input  logic [15:0]       CNV_X,
    input  logic [15:0]       CNV_Y,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    input  logic [DATA_W-1:0] S_TDATA,
    input  logic              S_TVALID,
    output logic              S_TREADY,
    input  logic              S_TUSER,
    input  logic              S_TLAST,
    output logic [DATA_W-1:0] M_TDATA,
    output logic              M_TVALID,
    input  logic              M_TREADY,
    output logic              M_TUSER,
    output logic              M_TLAST,
    output logic              LINE_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         org_x_q, org_x_d;
    logic [15:0]         org_y_q, org_y_d;
    logic [15:0]         cnv_x_q, cnv_x_d;
    logic [15:0]         cnv_y_q, cnv_y_d;
    logic [15:0]         x_cnt_q, x_cnt_d;
    logic [15:0]         y_cnt_q, y_cnt_d;
    logic [16:0]         acc_x_q, acc_x_d;
    logic [16:0]         acc_y_q, acc_y_d;
    logic                keep_y_q, keep_y_d;
    logic                first_out_q, first_out_d;
    logic                done_pend_q, done_pend_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
    logic                m_tvalid_q, m_tvalid_d;
    logic                m_tuser_q, m_tuser_d;
    logic                m_tlast_q, m_tlast_d;

    logic                s_tready;
    logic                xfer;
    logic                proc;
    logic                m_hs;
    logic                cfg_ok;
    logic                first_col;
    logic                last_col;
    logic                last_row;
    logic                frame_end;
    logic [16:0]         sum_x;
    logic [16:0]         sum_y;
    logic                keep_x;
    logic                keep_y_now;
    logic                keep_y;
    logic                keep_pix;

`ifdef AQ_REDUCE_TLAST_CHECK_EN
    logic                line_err_q, line_err_d;
`else
    logic                unused_tlast;
    assign unused_tlast = S_TLAST;
`endif

    always_comb begin
        s_tready = 1'b0;
        case (state_q)
            ST_WAIT_SOF: s_tready = 1'b1;
            ST_RUN:      s_tready = !m_tvalid_q || M_TREADY;
            default:     s_tready = 1'b0;
        endcase

        xfer = S_TVALID && s_tready;
        // Only the SOF beat leaves WAIT_SOF; everything before it is drained and dropped.
        proc = xfer && ((state_q == ST_RUN) || ((state_q == ST_WAIT_SOF) && S_TUSER));
        m_hs = m_tvalid_q && M_TREADY;

        cfg_ok = (CNV_X != 16'd0) && (CNV_X <= ORG_X) &&
                 (CNV_Y != 16'd0) && (CNV_Y <= ORG_Y);

        first_col = (x_cnt_q == 16'd0);
        last_col  = (x_cnt_q == org_x_q - 16'd1);
        last_row  = (y_cnt_q == org_y_q - 16'd1);
        frame_end = proc && last_col && last_row;

        sum_x      = acc_x_q + {1'b0, cnv_x_q};
        keep_x     = (sum_x >= {1'b0, org_x_q});
        sum_y      = acc_y_q + {1'b0, cnv_y_q};
        keep_y_now = (sum_y >= {1'b0, org_y_q});
        // Vertical decision is made on column 0 and held for the rest of the line.
        keep_y     = first_col ? keep_y_now : keep_y_q;
        keep_pix   = keep_x && keep_y;
    end

    always_comb begin
        state_d     = state_q;
        org_x_d     = org_x_q;
        org_y_d     = org_y_q;
        cnv_x_d     = cnv_x_q;
        cnv_y_d     = cnv_y_q;
        x_cnt_d     = x_cnt_q;
        y_cnt_d     = y_cnt_q;
        acc_x_d     = acc_x_q;
        acc_y_d     = acc_y_q;
        keep_y_d    = keep_y_q;
        first_out_d = first_out_q;
        done_pend_d = done_pend_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        m_tdata_d   = m_tdata_q;
        m_tvalid_d  = m_tvalid_q;
        m_tuser_d   = m_tuser_q;
        m_tlast_d   = m_tlast_q;
`ifdef AQ_REDUCE_TLAST_CHECK_EN
        line_err_d  = line_err_q;
`endif

        if (m_hs) begin
            m_tvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (done_pend_q) begin
                    if (m_hs) begin
                        done_d      = 1'b1;
                        done_pend_d = 1'b0;
                        busy_d      = 1'b0;
                    end
                end else if (START && !busy_q) begin
                    org_x_d = ORG_X;
                    org_y_d = ORG_Y;
                    cnv_x_d = CNV_X;
                    cnv_y_d = CNV_Y;
                    if (cfg_ok) begin
                        state_d     = ST_WAIT_SOF;
                        busy_d      = 1'b1;
                        x_cnt_d     = 16'd0;
                        y_cnt_d     = 16'd0;
                        acc_x_d     = 17'd0;
                        acc_y_d     = 17'd0;
                        keep_y_d    = 1'b0;
                        first_out_d = 1'b1;
`ifdef AQ_REDUCE_TLAST_CHECK_EN
                        line_err_d  = 1'b0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WAIT_SOF, ST_RUN: begin
                if (proc) begin
                    if (last_col) begin
                        x_cnt_d = 16'd0;
                        y_cnt_d = y_cnt_q + 16'd1;
                        acc_x_d = 17'd0;
                    end else begin
                        x_cnt_d = x_cnt_q + 16'd1;
                        acc_x_d = keep_x ? (sum_x - {1'b0, org_x_q}) : sum_x;
                    end

                    if (first_col) begin
                        keep_y_d = keep_y_now;
                        acc_y_d  = keep_y_now ? (sum_y - {1'b0, org_y_q}) : sum_y;
                    end

                    // s_tready guarantees the output register is free or draining now.
                    if (keep_pix) begin
                        m_tdata_d   = S_TDATA;
                        m_tvalid_d  = 1'b1;
                        m_tuser_d   = first_out_q;
                        m_tlast_d   = last_col;
                        first_out_d = 1'b0;
                    end

`ifdef AQ_REDUCE_TLAST_CHECK_EN
                    if ((state_q == ST_RUN) && (S_TLAST != last_col)) begin
                        line_err_d = 1'b1;
                    end
`endif

                    if (frame_end) begin
                        state_d     = ST_IDLE;
                        done_pend_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            org_x_q     <= 16'd0;
            org_y_q     <= 16'd0;
            cnv_x_q     <= 16'd0;
            cnv_y_q     <= 16'd0;
            x_cnt_q     <= 16'd0;
            y_cnt_q     <= 16'd0;
            acc_x_q     <= 17'd0;
            acc_y_q     <= 17'd0;
            keep_y_q    <= 1'b0;
            first_out_q <= 1'b0;
            done_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tuser_q   <= 1'b0;
            m_tlast_q   <= 1'b0;
`ifdef AQ_REDUCE_TLAST_CHECK_EN
            line_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            org_x_q     <= org_x_d;
            org_y_q     <= org_y_d;
            cnv_x_q     <= cnv_x_d;
            cnv_y_q     <= cnv_y_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            acc_x_q     <= acc_x_d;
            acc_y_q     <= acc_y_d;
            keep_y_q    <= keep_y_d;
            first_out_q <= first_out_d;
            done_pend_q <= done_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tuser_q   <= m_tuser_d;
            m_tlast_q   <= m_tlast_d;
`ifdef AQ_REDUCE_TLAST_CHECK_EN
            line_err_q  <= line_err_d;
`endif
        end
    end

    assign S_TREADY = s_tready;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign M_TDATA  = m_tdata_q;
    assign M_TVALID = m_tvalid_q;
    assign M_TUSER  = m_tuser_q;
    assign M_TLAST  = m_tlast_q;
`ifdef AQ_REDUCE_TLAST_CHECK_EN
    assign LINE_ERR = line_err_q;
`else
    assign LINE_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_aq_reduce_ctrl.sv
// Self-checking bench for aq_reduce_ctrl: table of frame configurations against an
// arithmetic decimation model, plus hand sequences for config reject and mid-frame reset.
module tb_aq_reduce_ctrl;
    localparam int DW = 24;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic [15:0]   ORG_X = 16'd0, ORG_Y = 16'd0, CNV_X = 16'd0, CNV_Y = 16'd0;
    logic          START = 1'b0;
    logic          BUSY, DONE, ERR;
    logic [DW-1:0] S_TDATA = '0;
    logic          S_TVALID = 1'b0;
    logic          S_TREADY;
    logic          S_TUSER = 1'b0, S_TLAST = 1'b0;
    logic [DW-1:0] M_TDATA;
    logic          M_TVALID;
    logic          M_TREADY = 1'b1;
    logic          M_TUSER, M_TLAST;
    logic          LINE_ERR;

    aq_reduce_ctrl #(.DATA_W(DW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ORG_X(ORG_X), .ORG_Y(ORG_Y), .CNV_X(CNV_X), .CNV_Y(CNV_Y),
        .START(START), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
        .S_TUSER(S_TUSER), .S_TLAST(S_TLAST),
        .M_TDATA(M_TDATA), .M_TVALID(M_TVALID), .M_TREADY(M_TREADY),
        .M_TUSER(M_TUSER), .M_TLAST(M_TLAST), .LINE_ERR(LINE_ERR)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int            rdy_mode = 0;
    int            stall_left = 0;
    bit            forced_stall = 0;
    logic [25:0]   got_q[$];
    logic [25:0]   exp_q[$];
    int            got_cyc[$];
    int            in_cyc[$];
    logic [DW-1:0] fdata[$];
    int            done_cnt = 0, done_cyc = 0, last_hs_cyc = 0, bp_cnt = 0;
    logic          prev_hold = 1'b0;
    logic [25:0]   prev_beat = '0;

    typedef struct {
        int ox; int oy; int cx; int cy;
        int mode;
        int exp_beats;
        bit bad_tlast;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output sink: drives M_TREADY, records handshakes, DONE pulses and hold stability.
    always @(negedge ACLK) begin
        if (rdy_mode == 2 && !forced_stall && M_TVALID === 1'b1) begin
            forced_stall = 1;
            stall_left = 20;
        end
        if (rdy_mode == 0) M_TREADY = 1'b1;
        else if (rdy_mode == 1) M_TREADY = 1'($urandom_range(0, 1));
        else if (stall_left > 0) begin
            M_TREADY = 1'b0;
            stall_left--;
        end else if ($urandom_range(0, 24) == 0) begin
            M_TREADY = 1'b0;
            stall_left = 19;
        end else M_TREADY = 1'($urandom_range(0, 1));
        #1;
        if (prev_hold) begin
            chk("hold_valid", M_TVALID, 1);
            chk("hold_beat", {M_TUSER, M_TLAST, M_TDATA}, prev_beat);
        end
        if (M_TVALID === 1'b1 && M_TREADY) begin
            got_q.push_back({M_TUSER, M_TLAST, M_TDATA});
            got_cyc.push_back(cyc);
            last_hs_cyc = cyc;
        end
        if (DONE === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (BUSY === 1'b1 && S_TVALID && S_TREADY === 1'b0) bp_cnt++;
        prev_hold = (M_TVALID === 1'b1) && !M_TREADY && !ARESET;
        prev_beat = {M_TUSER, M_TLAST, M_TDATA};
    end

    task automatic make_frame(input int ox, input int oy);
        fdata.delete();
        for (int y = 0; y < oy; y++)
            for (int x = 0; x < ox; x++)
                fdata.push_back({8'($urandom), 8'(y), 8'(x)});
    endtask

    // A pixel index i of n survives a ratio c/n when floor((i+1)c/n) steps past floor(ic/n).
    task automatic build_model(input int ox, input int oy, input int cx, input int cy);
        bit first = 1;
        logic lst;
        exp_q.delete();
        for (int y = 0; y < oy; y++)
            for (int x = 0; x < ox; x++)
                if ((((y + 1) * cy) / oy != (y * cy) / oy) &&
                    (((x + 1) * cx) / ox != (x * cx) / ox)) begin
                    lst = (x == ox - 1);
                    exp_q.push_back({first, lst, fdata[y * ox + x]});
                    first = 0;
                end
    endtask

    task automatic start_pulse(input int ox, input int oy, input int cx, input int cy);
        @(negedge ACLK);
        ORG_X = 16'(ox); ORG_Y = 16'(oy); CNV_X = 16'(cx); CNV_Y = 16'(cy);
        START = 1'b1;
        @(negedge ACLK);
        START = 1'b0;
        ORG_X = 16'($urandom); ORG_Y = 16'($urandom);
        CNV_X = 16'($urandom); CNV_Y = 16'($urandom);
        #1;
    endtask

    // Sends two non-SOF beats, then n frame beats in raster order; valid is held until accepted.
    task automatic drive_beats(input int ox, input int n, input bit gaps,
                               input bit busy_start, input bit bad_tlast);
        int  idx = 0;
        int  g = 2;
        int  guard = 0;
        bit  pend = 0;
        bit  v;
        bit  bs_done = 0;
        bit  bs_pulse = 0;
        int  x, y;
        while (idx < n && guard < 6000) begin
            @(negedge ACLK);
            guard++;
            if (bs_pulse) begin
                START = 1'b0;
                bs_pulse = 0;
            end
            if (!pend) begin
                v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (v) begin
                    if (g > 0) begin
                        S_TDATA = DW'($urandom);
                        S_TUSER = 1'b0;
                        S_TLAST = 1'b0;
                    end else begin
                        x = idx % ox;
                        y = idx / ox;
                        S_TDATA = fdata[idx];
                        S_TUSER = (idx == 0) || (gaps && $urandom_range(0, 6) == 0);
                        S_TLAST = (bad_tlast && y == 0) ? (x == 5) : (x == ox - 1);
                    end
                    pend = 1;
                end
                S_TVALID = v;
            end
            if (busy_start && idx == ox && !bs_done) begin
                START = 1'b1;
                ORG_X = 16'($urandom_range(1, 9)); ORG_Y = 16'($urandom_range(1, 9));
                CNV_X = 16'd1; CNV_Y = 16'd1;
                bs_done = 1;
                bs_pulse = 1;
            end
            #1;
            if (S_TVALID && S_TREADY === 1'b1) begin
                pend = 0;
                if (g > 0) g--;
                else begin
                    in_cyc.push_back(cyc);
                    idx++;
                end
            end
        end
        if (idx < n) chk("drive_timeout", idx, n);
        @(negedge ACLK);
        S_TVALID = 1'b0;
        START = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int nchk;
        make_frame(v.ox, v.oy);
        build_model(v.ox, v.oy, v.cx, v.cy);
        got_q.delete(); got_cyc.delete(); in_cyc.delete();
        done_cnt = 0; bp_cnt = 0; forced_stall = 0; stall_left = 0;
        rdy_mode = v.mode;
        start_pulse(v.ox, v.oy, v.cx, v.cy);
        chk("busy_after_start", BUSY, 1);
        chk("no_err_valid_cfg", ERR, 0);
        drive_beats(v.ox, v.ox * v.oy, v.mode != 0, v.mode != 0, v.bad_tlast);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge ACLK);
        repeat (4) @(negedge ACLK);
        #2;
        chk("done_pulses", done_cnt, 1);
        chk("beat_count_table", got_q.size(), v.exp_beats);
        chk("beat_count_model", got_q.size(), exp_q.size());
        nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < nchk; k++) chk($sformatf("beat%0d", k), got_q[k], exp_q[k]);
        chk("done_after_last_hs", done_cyc - last_hs_cyc, 1);
        chk("busy_after_done", BUSY, 0);
`ifdef AQ_REDUCE_TLAST_CHECK_EN
        chk("line_err", LINE_ERR, v.bad_tlast);
`else
        chk("line_err", LINE_ERR, 0);
`endif
        if (v.mode == 2) chk("backpressure_seen", bp_cnt > 0, 1);
        if (v.ox == v.cx && v.oy == v.cy && v.mode == 0 && got_cyc.size() == in_cyc.size())
            for (int k = 0; k < got_cyc.size(); k++)
                chk($sformatf("latency%0d", k), got_cyc[k] - in_cyc[k], 1);
        rdy_mode = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   pos36[8];
        pos36 = '{16'h0101, 16'h0103, 16'h0105, 16'h0107, 16'h0301, 16'h0303, 16'h0305, 16'h0307};
        vecs[0] = '{8, 4, 4, 2, 0, 8, 0};
        vecs[1] = '{5, 1, 2, 1, 0, 2, 0};
        vecs[2] = '{3, 3, 3, 3, 0, 9, 0};
        vecs[3] = '{8, 4, 4, 2, 2, 8, 0};
        vecs[4] = '{7, 5, 3, 2, 1, 6, 0};
        vecs[5] = '{1, 1, 1, 1, 0, 1, 0};
        vecs[6] = '{10, 3, 1, 3, 2, 3, 0};
        vecs[7] = '{8, 4, 4, 2, 0, 8, 1};
        vecs[8] = '{6, 6, 4, 5, 1, 20, 0};

        repeat (3) @(negedge ACLK);
        #1;
        chk("reset_outputs", {M_TVALID, M_TUSER, M_TLAST, M_TDATA, DONE, ERR, LINE_ERR, BUSY, S_TREADY}, 0);
        ARESET = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i]);
            if (i == 0)
                for (int k = 0; k < 8 && k < got_q.size(); k++)
                    chk($sformatf("pos8x4_%0d", k), got_q[k][15:0], pos36[k]);
            if (i == 1 && got_q.size() == 2) begin
                chk("col5x1_first", got_q[0][7:0], 2);
                chk("col5x1_last", {got_q[1][24], got_q[1][7:0]}, 9'h104);
            end
        end

        // Rejected configurations: one-cycle ERR, no frame starts.
        start_pulse(8, 4, 0, 2);
        chk("err_cnvx0", ERR, 1);
        chk("err_cnvx0_busy", BUSY, 0);
        chk("err_cnvx0_tready", S_TREADY, 0);
        @(negedge ACLK); #1;
        chk("err_cnvx0_pulse_end", ERR, 0);
        start_pulse(8, 4, 4, 5);
        chk("err_cnvy5", ERR, 1);
        chk("err_cnvy5_busy", BUSY, 0);
        @(negedge ACLK); #1;
        chk("err_cnvy5_pulse_end", {ERR, BUSY, S_TREADY}, 0);

        // Reset partway through line 2 abandons the frame without DONE.
        rdy_mode = 0;
        make_frame(8, 4);
        done_cnt = 0;
        start_pulse(8, 4, 4, 2);
        drive_beats(8, 20, 0, 0, 0);
        ARESET = 1'b1;
        @(negedge ACLK); #1;
        chk("midreset_outputs", {M_TVALID, M_TUSER, M_TLAST, M_TDATA, DONE, ERR, LINE_ERR, BUSY, S_TREADY}, 0);
        ARESET = 1'b0;
        repeat (30) @(negedge ACLK);
        chk("midreset_no_done", done_cnt, 0);
        run_frame(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
